// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: per-source frame handshake plus the shared FIFO write port
interface fifo_wr_arbiter_if #(
  parameter int N = 4,
  parameter int WIDTH = 512
);
  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       req_last;
  logic [N-1:0]       req_ready;
  logic [WIDTH-1:0]   buf_data;
  logic               buf_write;
  logic               buf_full;
  modport master (output req_valid, req_data, req_last, buf_full, input req_ready, buf_data, buf_write);
  modport slave (input req_valid, req_data, req_last, buf_full, output req_ready, buf_data, buf_write);
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin frame arbiter sharing one FIFO write port among N sources
module fifo_wr_arbiter #(
  parameter int N = 4,
  parameter int WIDTH = 512,
  parameter int MAX_BEATS = 16,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  fifo_wr_arbiter_if.slave bus,
  output logic [ID_W-1:0] grant_id,
  output logic            busy,
  output logic [7:0]      beat_cnt,
  output logic            err_overrun
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  logic [0:0] state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d, last_q, last_d, pick, idx;
  logic [7:0] cnt_q, cnt_d;
  logic err_q, err_d, found, rdy, accept, done;
  // search starts just after the previous winner so every source gets a turn
  always_comb begin
    pick = last_q;
    idx = last_q;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = ID_W'((int'(last_q) + k) % N);
      if (!found && bus.req_valid[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  assign rdy = state_q == BURST && !reset && !bus.buf_full;
  assign accept = rdy && bus.req_valid[grant_q];
  assign done = accept && (bus.req_last[grant_q] || cnt_q == 8'(MAX_BEATS - 1));
  assign bus.req_ready = rdy ? N'(1) << grant_q : '0;
  assign bus.buf_write = accept;
  assign bus.buf_data = bus.req_data[grant_q*WIDTH +: WIDTH];
  always_comb begin
    state_d = (state_q == IDLE) ? (found ? BURST : IDLE) : (done ? IDLE : BURST);
    grant_d = (state_q == IDLE && found) ? pick : grant_q;
    last_d = done ? grant_q : last_q;
    cnt_d = (state_q == IDLE) ? (found ? 8'd0 : cnt_q) : (accept ? cnt_q + 8'd1 : cnt_q);
    err_d = err_q | (done & ~bus.req_last[grant_q]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= ID_W'(N - 1);
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign grant_id = grant_q;
  assign busy = state_q == BURST;
  assign beat_cnt = cnt_q;
  assign err_overrun = err_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random frames checked against a behavioural arbitration model
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int MB = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fifo_wr_arbiter_if #(.N(N), .WIDTH(W)) bus();
  logic [1:0] gid;
  logic busy;
  logic [7:0] bcnt;
  logic err;
  fifo_wr_arbiter #(.N(N), .WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk(clk), .reset(rst), .bus(bus.slave),
    .grant_id(gid), .busy(busy), .beat_cnt(bcnt), .err_overrun(err)
  );
  int n_cmp = 0, n_bad = 0, cycn = 0;
  int m_busy = 0, m_g = 0, m_last = N - 1, m_cnt = 0, m_err = 0;
  logic [N-1:0] acc_q = '0;
  int wg[$], wd[$], wc[$];
  int act[N], pos[N], len[N], lenfix[N], seq[N];
  logic [N-1:0] en = '0, hold = '0;
  int pstart = 0, pdrop = 0, pfull = 0;
  logic full_force = 1'b0;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at cycle %0d", nm, a, e, cycn);
    end
  endtask

  // reference: one granted source at a time, round-robin from the last winner
  initial begin
    logic [N-1:0] er, ea;
    int j;
    forever begin
      @(negedge clk);
      cycn++;
      er = (m_busy != 0 && !rst && !bus.buf_full) ? N'(1 << m_g) : '0;
      ea = er & bus.req_valid;
      chk("req_ready", bus.req_ready, er);
      chk("buf_write", bus.buf_write, |ea);
      if (|ea) chk("buf_data", bus.buf_data, bus.req_data[m_g*W +: W]);
      chk("grant_id", gid, m_g);
      chk("busy", busy, m_busy);
      chk("beat_cnt", bcnt, m_cnt);
      chk("err_overrun", err, m_err);
      if (bus.buf_write) begin
        wg.push_back(gid);
        wd.push_back(bus.buf_data);
        wc.push_back(cycn);
      end
      acc_q = ea;
      if (rst) begin
        m_busy = 0; m_g = 0; m_last = N - 1; m_cnt = 0; m_err = 0;
      end else if (m_busy == 0) begin
        for (int k = 1; k <= N; k++) begin
          j = (m_last + k) % N;
          if (m_busy == 0 && bus.req_valid[j]) begin
            m_g = j; m_busy = 1; m_cnt = 0;
          end
        end
      end else if (|ea) begin
        m_cnt++;
        if (bus.req_last[m_g] || m_cnt == MB) begin
          if (!bus.req_last[m_g]) m_err = 1;
          m_busy = 0;
          m_last = m_g;
        end
      end
    end
  end

  task automatic start_frame(int i, int l);
    act[i] = 1; pos[i] = 0; len[i] = l;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (acc_q[i]) begin
        pos[i]++; seq[i]++;
        if (pos[i] >= len[i]) act[i] = 0;
      end
      if (act[i] == 0 && en[i] && $urandom_range(99) < pstart)
        start_frame(i, lenfix[i] > 0 ? lenfix[i] : int'($urandom_range(20, 1)));
      bus.req_valid[i] = act[i] != 0 && !hold[i] && !($urandom_range(99) < pdrop);
      bus.req_last[i] = pos[i] == len[i] - 1;
      bus.req_data[i*W +: W] = W'(seq[i]);
    end
    bus.buf_full = full_force || $urandom_range(99) < pfull;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    #1;
  endtask

  task automatic quiet();
    for (int i = 0; i < N; i++) begin
      act[i] = 0; lenfix[i] = 0;
    end
    en = '0; hold = '0; full_force = 1'b0;
    pstart = 0; pdrop = 0; pfull = 0;
  endtask

  task automatic clearlog();
    wg.delete(); wd.delete(); wc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    clearlog();
  endtask

  initial begin
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.buf_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      act[i] = 0; pos[i] = 0; len[i] = 1; lenfix[i] = 0; seq[i] = i * 4096;
    end
    repeat (3) step();
    chk("rst_grant", gid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", bcnt, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_write", bus.buf_write, 0);
    rst = 1'b0;
    clearlog();
    // single source, three beats
    seq[2] = 'hA;
    start_frame(2, 3);
    step();
    step();
    chk("a_grant", gid, 2);
    chk("a_busy", busy, 1);
    repeat (5) step();
    chk("a_nwrites", wg.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("a_gid", k < wg.size() ? 64'(wg[k]) : 'x, 2);
      chk("a_data", k < wd.size() ? 64'(wd[k]) : 'x, 'hA + k);
      chk("a_back2back", k < wc.size() ? 64'(wc[k] - wc[0]) : 'x, k);
    end
    chk("a_busy_end", busy, 0);
    chk("a_cnt_end", bcnt, 3);
    // round-robin with all sources streaming one-beat frames
    quiet();
    en = '1; pstart = 100;
    for (int i = 0; i < N; i++) lenfix[i] = 1;
    do_reset();
    repeat (14) step();
    for (int k = 0; k < 6; k++) chk("b_order", k < wg.size() ? 64'(wg[k]) : 'x, k % 4);
    for (int k = 1; k < 6; k++) chk("b_gap", k < wc.size() ? 64'(wc[k] - wc[k-1]) : 'x, 2);
    // backpressure in the middle of a four-beat frame
    quiet();
    do_reset();
    seq[1] = 256;
    start_frame(1, 4);
    step();
    step();
    full_force = 1'b1;
    repeat (3) begin
      step();
      chk("c_ready", bus.req_ready, 0);
      chk("c_write", bus.buf_write, 0);
    end
    full_force = 1'b0;
    repeat (6) step();
    chk("c_nwrites", wg.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("c_gid", k < wg.size() ? 64'(wg[k]) : 'x, 1);
      chk("c_data", k < wd.size() ? 64'(wd[k]) : 'x, 256 + k);
    end
    // overrun: twenty beats without last, source 1 waiting
    quiet();
    do_reset();
    seq[0] = 0;
    start_frame(0, 20);
    start_frame(1, 2);
    repeat (18) step();
    chk("d_busy", busy, 0);
    chk("d_err", err, 1);
    chk("d_cnt", bcnt, 16);
    repeat (12) step();
    chk("d_nwrites", wg.size(), 22);
    for (int k = 0; k < 22; k++)
      chk("d_gid", k < wg.size() ? 64'(wg[k]) : 'x, (k == 16 || k == 17) ? 1 : 0);
    for (int k = 18; k < 22; k++) chk("d_data", k < wd.size() ? 64'(wd[k]) : 'x, k - 2);
    chk("d_err_sticky", err, 1);
    // reset in the middle of a frame from source 3
    quiet();
    clearlog();
    seq[3] = 'h300;
    start_frame(3, 5);
    step();
    step();
    @(posedge clk);
    #1;
    rst = 1'b1;
    start_frame(0, 1);
    drive();
    #1;
    chk("e_write", bus.buf_write, 0);
    chk("e_ready", bus.req_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
    #1;
    chk("e_grant", gid, 0);
    chk("e_err", err, 0);
    chk("e_busy", busy, 0);
    clearlog();
    repeat (12) step();
    chk("e_first", wg.size() > 0 ? 64'(wg[0]) : 'x, 0);
    chk("e_second", wg.size() > 1 ? 64'(wg[1]) : 'x, 3);
    chk("e_resume", wd.size() > 1 ? 64'(wd[1]) : 'x, 'h301);
    // stalled grant holds while others wait
    quiet();
    do_reset();
    seq[2] = 'h200;
    start_frame(2, 3);
    step();
    step();
    hold[2] = 1'b1;
    start_frame(0, 1);
    start_frame(3, 1);
    repeat (10) begin
      step();
      chk("f_ready0", bus.req_ready[0], 0);
      chk("f_grant", gid, 2);
    end
    hold[2] = 1'b0;
    repeat (10) step();
    chk("f_nwrites", wg.size(), 5);
    for (int k = 0; k < 5; k++)
      chk("f_order", k < wg.size() ? 64'(wg[k]) : 'x, k < 3 ? 2 : (k == 3 ? 3 : 0));
    // random traffic, stalls, backpressure and occasional reset
    quiet();
    do_reset();
    en = '1; pstart = 30; pdrop = 15; pfull = 20;
    repeat (4000) begin
      rst = $urandom_range(499) == 0;
      step();
    end
    rst = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-side arbiter that shares one PHY staging FIFO among N frame sources. Each source offers multi-beat frames over a valid/ready handshake. The arbiter grants one source at a time, locks the grant until the frame's last beat, and drives the FIFO write port. The grant is released early, with a sticky error flag, if a frame exceeds MAX_BEATS.

Parameters:
N, 4, number of requesters (2..8)
WIDTH, 512, data beat width in bits; matches the FIFO data width
MAX_BEATS, 16, maximum beats per frame before forced release (1..255)
ID_W, derived localparam = clog2(N), minimum 1; width of grant_id

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  N  per-source beat valid
req_data  input  N*WIDTH  per-source beat data; source i occupies bits [i*WIDTH +: WIDTH]
req_last  input  N  per-source last-beat-of-frame marker, qualified by req_valid
req_ready  output  N  per-source beat accepted this cycle, combinational
buf_data  output  WIDTH  data to FIFO, combinational mux of the granted source
buf_write  output  1  FIFO write strobe, combinational
buf_full  input  1  FIFO full flag
grant_id  output  ID_W  currently/last granted source, registered
busy  output  1  1 while in BURST, registered
beat_cnt  output  8  beats accepted in the current frame, registered
err_overrun  output  1  sticky: a frame hit MAX_BEATS without req_last; cleared only by reset

Behaviour:
- Reset, synchronous, sampled at posedge clk:
  - state = IDLE, grant_id = 0, last_grant = N-1 (so source 0 wins first), busy = 0, beat_cnt = 0, err_overrun = 0.
  - While reset is high, req_ready = 0 and buf_write = 0.
- State IDLE:
  - req_ready = 0, buf_write = 0, buf_data = req_data of grant_id (don't-care).
  - If any req_valid: select the first asserted index searching last_grant+1, last_grant+2, ... modulo N.
  - Register that index into grant_id, set busy = 1, beat_cnt = 0, go to BURST.
  - Arbitration latency is exactly 1 cycle: a request asserted in cycle t can first be accepted in cycle t+1.
- State BURST, g = grant_id:
  - req_ready[g] = !buf_full; all other req_ready bits = 0.
  - accept = req_valid[g] & req_ready[g]; buf_write = accept; buf_data = req_data slice g.
  - On accept: beat_cnt = beat_cnt + 1.
  - accept & req_last[g]: go to IDLE, last_grant = g, busy = 0.
  - accept & !req_last[g] & beat_cnt == MAX_BEATS-1: set err_overrun = 1, go to IDLE, last_grant = g, busy = 0.
    - The source's remaining beats compete again as a new frame.
  - No accept (source idle or buf_full): hold state. There is no timeout on a stalled grant.
- Dead cycle: one IDLE cycle always separates consecutive frames. Peak throughput is one frame per frame-length+1 cycles.
- buf_full is sampled combinationally; the arbiter never asserts buf_write while buf_full = 1.
- Requesters that drop req_valid mid-frame keep the grant; other sources wait.
- Valid requests in IDLE are never dropped; a non-granted source waits at most N-1 frames (round-robin fairness).
- Reset asserted mid-burst: frame abandoned, no write that cycle; next arbitration starts at source 0.
- req_data/req_last of non-granted sources are ignored.

Test Plan:
- Single source: N=4; source 2 sends a 3-beat frame (data 0xA,0xB,0xC, last on beat 3), buf_full = 0 -> grant_id=2 one cycle after valid; buf_write high 3 consecutive cycles with data A,B,C; busy falls after beat 3; beat_cnt = 3.
- Round-robin: all 4 sources continuously request 1-beat frames from reset -> grant order 0,1,2,3,0,1; each write is separated by exactly one idle cycle.
- Backpressure: source 1 sends a 4-beat frame; buf_full = 1 during beats 2-3 for 3 cycles -> req_ready[1] = 0 and buf_write = 0 while full; all 4 beats written in order; no duplicated beats.
- Overrun: MAX_BEATS=16; source 0 sends 20 beats with no last -> after the 16th accepted beat err_overrun = 1 and busy = 0; the next grant goes to source 1 if it is requesting, else back to source 0; err_overrun stays 1 until reset.
- Reset mid-frame: assert reset during beat 2 of a 5-beat frame from source 3 -> that cycle buf_write = 0; after reset grant_id = 0, err_overrun = 0; with sources 0 and 3 requesting, source 0 is granted first.
- Stalled grant: source 2 is granted, then drops req_valid for 10 cycles while source 0 requests -> no grant change and req_ready[0] = 0 throughout; source 2 resumes and completes, then source 3 (if requesting) or source 0 is granted next.
